// File: rtl/generic_ram_pipe.sv
// generic_ram_pipe: single-port RAM behind a valid/ready request channel,
// with a LATENCY-deep read pipeline feeding a fall-through response FIFO.
// Define RAM_WRITE_RESP_EN to make every accepted write return a response too.
module generic_ram_pipe #(
  parameter int    WIDTH    = 32,
  parameter int    DEPTH    = 1024,
  parameter int    LATENCY  = 1,
  parameter string DATAFILE = "",
  localparam int   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int   NB       = WIDTH / 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [NB-1:0]    req_be,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
);

  // Response FIFO depth and credit limit are the same number.
  localparam int BUF = LATENCY + 1;
  localparam int PW  = (BUF > 1) ? $clog2(BUF) : 1;
  localparam int CW  = $clog2(BUF + 1);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(BUF - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_BUF  = CW'(BUF);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

`ifdef RAM_WRITE_RESP_EN
  localparam logic WRITE_RESP = 1'b1;
`else
  localparam logic WRITE_RESP = 1'b0;
`endif

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] pipe_data [LATENCY];
  logic [LATENCY-1:0] pipe_valid;
  logic [LATENCY-1:0] pipe_err;

  logic [WIDTH-1:0] fifo_data [BUF];
  logic [BUF-1:0]   fifo_err;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    fifo_cnt;
  logic [CW-1:0]    outstanding;

  logic             accept;
  logic             in_range;
  logic             enter;
  logic             fifo_empty;
  logic             resp_fire;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_data;
  logic             head_err;

  // Credit check depends only on the registered outstanding count.
  assign req_ready  = (outstanding != CNT_BUF);
  assign accept     = req_valid & req_ready;
  assign in_range   = ({1'b0, req_addr} < DEPTH_W);
  assign enter      = accept & (~req_we | WRITE_RESP);
  assign fifo_empty = (fifo_cnt == '0);
  assign resp_valid = ~fifo_empty | pipe_valid[LATENCY-1];
  assign resp_fire  = resp_valid & resp_ready;
  // The last stage bypasses the FIFO only when the FIFO is empty and the
  // consumer takes the word in the same cycle.
  assign push       = pipe_valid[LATENCY-1] & ~(fifo_empty & resp_fire);
  assign pop        = ~fifo_empty & resp_fire;
  assign resp_rdata = resp_valid ? head_data : '0;
  assign resp_err   = resp_valid ? head_err : 1'b0;

  // Zero-fill the array at time 0.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Byte-lane write port; out-of-range writes are accepted but dropped.
  always_ff @(posedge clock) begin
    if (accept && req_we && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // Select the response head: oldest FIFO entry, or the last stage when empty.
  always_comb begin
    head_data = '0;
    head_err  = 1'b0;
    if (!fifo_empty) begin
      head_data = fifo_data[rd_ptr];
      head_err  = fifo_err[rd_ptr];
    end else begin
      head_data = pipe_data[LATENCY-1];
      head_err  = pipe_err[LATENCY-1];
    end
  end

  // Read pipeline, response FIFO and credit counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid  <= '0;
      pipe_err    <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_data[i] <= '0;
      for (int i = 0; i < BUF; i++) fifo_data[i] <= '0;
      fifo_err    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
    end else begin
      // Stage 0 samples the array at the accepting edge.
      pipe_valid[0] <= enter;
      pipe_err[0]   <= enter & ~in_range;
      pipe_data[0]  <= (enter && !req_we && in_range) ? mem[req_addr] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end

      if (push) begin
        fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
        fifo_err[wr_ptr]  <= pipe_err[LATENCY-1];
        wr_ptr            <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      end

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase

      case ({enter, resp_fire})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_generic_ram_pipe.sv
// Self-checking bench for generic_ram_pipe: directed steps followed by random
// traffic, all checked against a queue-based response model.
module tb_generic_ram_pipe;

  localparam int W     = 32;
  localparam int DEPTH = 12;
  localparam int LAT   = 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int NB    = W / 8;
  localparam int BUF   = LAT + 1;

`ifdef RAM_WRITE_RESP_EN
  localparam bit WRESP = 1'b1;
`else
  localparam bit WRESP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [NB-1:0] req_be = '0;
  logic [W-1:0]  req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [W-1:0]  resp_rdata;
  logic          resp_err;

  generic_ram_pipe #(.WIDTH(W), .DEPTH(DEPTH), .LATENCY(LAT), .DATAFILE("")) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           due;
  } resp_t;

  resp_t        q[$];
  logic [W-1:0] mem_m [DEPTH];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  logic         exp_valid;
  logic         exp_ready;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs: a response is visible once its due cycle is reached;
  // the requester is stalled whenever BUF responses are owed.
  task automatic check_outputs(input string pfx);
    exp_valid = (q.size() > 0) && (q[0].due <= cyc);
    exp_ready = (q.size() != BUF);
    chk({pfx, ".req_ready"}, W'(req_ready), W'(exp_ready));
    chk({pfx, ".resp_valid"}, W'(resp_valid), W'(exp_valid));
    chk({pfx, ".resp_rdata"}, resp_rdata, exp_valid ? q[0].data : '0);
    chk({pfx, ".resp_err"}, W'(resp_err), W'(exp_valid ? q[0].err : 1'b0));
  endtask

  task automatic cycle(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [NB-1:0] be, input logic [W-1:0] wd, input logic rr);
    logic  acc;
    logic  fire;
    resp_t e;
    @(negedge clock);
    req_valid = v; req_we = we; req_addr = a; req_be = be; req_wdata = wd; resp_ready = rr;
    #1;
    check_outputs("cyc");
    acc  = v && exp_ready;
    fire = exp_valid && rr;
    @(posedge clock);
    if (fire) void'(q.pop_front());
    if (acc) begin
      if (!we || WRESP) begin
        e.err  = (int'(a) >= DEPTH);
        e.data = (we || e.err) ? '0 : mem_m[a];
        e.due  = cyc + LAT;
        q.push_back(e);
      end
      if (we && int'(a) < DEPTH) begin
        for (int b = 0; b < NB; b++) if (be[b]) mem_m[a][8*b +: 8] = wd[8*b +: 8];
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic wr(input int a, input logic [NB-1:0] be, input logic [W-1:0] d);
    cycle(1'b1, 1'b1, AW'(a), be, d, 1'b1);
  endtask

  task automatic rd(input int a, input logic rr);
    cycle(1'b1, 1'b0, AW'(a), '0, '0, rr);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    #1;
    q.delete();
    check_outputs("rst");
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    check_outputs("rst_hold");
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    // Reset state
    do_reset();
    idle(2);

    // Full write then read back; exact latency checked by the model
    wr(3, 4'hF, 32'hDEADBEEF);
    rd(3, 1'b1);
    idle(LAT + 1);

    // Partial byte-lane write
    wr(5, 4'hF, 32'h11223344);
    wr(5, 4'b0101, 32'hAABBCCDD);
    wr(6, 4'h0, 32'hFFFFFFFF);
    rd(5, 1'b1);
    rd(6, 1'b1);
    idle(LAT + 1);

    // Back-to-back reads with the consumer always ready
    for (int a = 0; a < 8; a++) wr(a, 4'hF, W'(32'h100 + a));
    for (int a = 0; a < 8; a++) rd(a, 1'b1);
    idle(LAT + 1);

    // Backpressure: fill all credits, hold, then release one handshake
    for (int i = 0; i < 5; i++) rd(i, 1'b0);
    cycle(1'b1, 1'b0, AW'(1), '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) rd(7, 1'b0);
    idle(BUF + LAT + 2);

    // Out-of-range write and read, then sweep every legal address
    wr(13, 4'hF, 32'hCAFEF00D);
    rd(13, 1'b1);
    rd(15, 1'b1);
    for (int a = 0; a < DEPTH; a++) rd(a, 1'b1);
    idle(LAT + 1);

    // Reset with reads in flight: nothing stale may come out afterwards
    rd(2, 1'b0);
    rd(3, 1'b0);
    do_reset();
    idle(LAT + 4);
    rd(3, 1'b1);
    wr(2, 4'hF, 32'h12345678);
    idle(LAT + 2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            AW'($urandom_range(0, 15)), NB'($urandom), W'($urandom),
            ($urandom_range(0, 3) != 0));
    end
    idle(BUF + LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
